// File: rtl/ps2_scancode_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_scancode_sequencer
//
// Drains the ps2controller byte mailbox with a received/read_ack handshake,
// folds the E0 (extended) and F0 (break) prefixes into whole key events, and
// queues those events in a first-word fall-through FIFO for the CPU. It also
// keeps a level flag that follows the game's jump key.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-low reset
//   received       ps2controller: a byte is available
//   received_data  ps2controller: byte value, stable while received=1
//   read_ack       to ps2controller: byte consumed (held until received drops)
//   evt_valid      event FIFO is non-empty
//   evt_data       head event {brk, ext, code[7:0]}; zero when the FIFO is empty
//   evt_pop        CPU consumes the head event (ignored when empty)
//   overflow       sticky: an event was dropped because the FIFO was full
//   ovf_clr        clears overflow (a simultaneous new overflow wins)
//   jump_down      JUMP_CODE is currently held down
// ---------------------------------------------------------------------------
module ps2_scancode_sequencer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TIMEOUT   = 50000,
    parameter logic [7:0]  JUMP_CODE = 8'h29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       received,
    input  logic [7:0] received_data,
    output logic       read_ack,
    output logic       evt_valid,
    output logic [9:0] evt_data,
    input  logic       evt_pop,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       jump_down
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACK    = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    // Bytes the keyboard sends as status/acknowledge traffic; never key events.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    state_t          state_q,    state_d;
    logic [7:0]      byte_q,     byte_d;
    logic            read_ack_q, read_ack_d;
    logic            brk_q,      brk_d;
    logic            ext_q,      ext_d;
    logic [TW-1:0]   tmr_q,      tmr_d;
    logic            jump_q,     jump_d;
    logic            overflow_q, overflow_d;
    logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [9:0]      mem_q [DEPTH];

    logic            push;
    logic [9:0]      push_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        read_ack_d = read_ack_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        tmr_d      = tmr_q;
        jump_d     = jump_q;
        push       = 1'b0;
        push_data  = {brk_q, ext_q, byte_q};

        case (state_q)
            S_IDLE: begin
                if (received) begin
                    byte_d     = received_data;
                    read_ack_d = 1'b1;
                    state_d    = S_ACK;
                end
            end
            S_ACK: begin
                // Hold the acknowledge until the controller retracts received.
                if (!received) begin
                    read_ack_d = 1'b0;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_IDLE;
                if (byte_q == 8'hE0) begin
                    ext_d = 1'b1;
                    tmr_d = TW'(TIMEOUT);
                end else if (byte_q == 8'hF0) begin
                    brk_d = 1'b1;
                    tmr_d = TW'(TIMEOUT);
                end else if (!is_discard(byte_q)) begin
                    push  = 1'b1;
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                read_ack_d = 1'b0;
            end
        endcase

        // A stale prefix (keyboard reset mid-sequence, lost byte) must not
        // attach itself to an unrelated later key. DECODE owns the flags in
        // its own cycle, so the timer only runs elsewhere.
        if ((state_q != S_DECODE) && (brk_q || ext_q)) begin
            if (tmr_q == '0) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                tmr_d = tmr_q - 1'b1;
            end
        end

        // The jump level tracks the key itself, so it follows every decoded
        // event whether or not the FIFO had room for it.
        if (push && !ext_q && (byte_q == JUMP_CODE)) begin
            jump_d = !brk_q;
        end
    end

    // Event FIFO bookkeeping. A pop on a full FIFO frees the slot the
    // simultaneous push needs; a pop on an empty FIFO has nothing to take.
    always_comb begin
        fifo_full  = (count_q == CW'(DEPTH));
        fifo_empty = (count_q == '0);
        do_pop     = evt_pop && !fifo_empty;
        do_push    = push && (!fifo_full || do_pop);

        wr_ptr_d   = do_push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;

        count_d    = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end

        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (push && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            byte_q     <= 8'h00;
            read_ack_q <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            tmr_q      <= '0;
            jump_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            read_ack_q <= read_ack_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            tmr_q      <= tmr_d;
            jump_q     <= jump_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after it is written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign read_ack  = read_ack_q;
    assign evt_valid = !fifo_empty;
    assign evt_data  = fifo_empty ? 10'h000 : mem_q[rd_ptr_q];
    assign overflow  = overflow_q;
    assign jump_down = jump_q;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
module tb_ps2_scancode_sequencer;

    localparam int          DEPTH   = 8;
    localparam int          TIMEOUT = 40;
    localparam logic [7:0]  JUMP    = 8'h29;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       received = 1'b0;
    logic [7:0] received_data = 8'h00;
    logic       read_ack;
    logic       evt_valid;
    logic [9:0] evt_data;
    logic       evt_pop = 1'b0;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic       jump_down;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int unsigned cyc    = 0;

    // Reference model state: expected queue contents and flags.
    logic [9:0]  mq[$];
    bit          m_ovf, m_jump, m_brk, m_ext;
    int unsigned prefix_cyc;

    typedef struct {
        logic [23:0] bytes;   // byte j at [8*j +: 8]
        int          n;
        logic        ev;
        logic [9:0]  data;
        logic        jmp;
    } vec_t;

    vec_t vt[10];

    always #5 clk = ~clk;

    ps2_scancode_sequencer #(
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .JUMP_CODE(JUMP)
    ) dut (
        .clk(clk), .rst(rst),
        .received(received), .received_data(received_data),
        .read_ack(read_ack),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_pop(evt_pop),
        .overflow(overflow), .ovf_clr(ovf_clr),
        .jump_down(jump_down)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one byte, hold received for 'hold' cycles, then let it decode.
    // pop_dec / clr_dec are asserted during the DECODE cycle.
    task automatic send_byte(input logic [7:0] b, input int hold, input bit pop_dec, input bit clr_dec);
        received      = 1'b1;
        received_data = b;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("read_ack_high", read_ack, 1);
        end
        received = 1'b0;
        tick();
        check("read_ack_low", read_ack, 0);
        evt_pop = pop_dec;
        ovf_clr = clr_dec;
        tick();
        evt_pop = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (evt_valid && guard < 2 * DEPTH) begin
            evt_pop = 1'b1;
            tick();
            evt_pop = 1'b0;
            guard++;
        end
        check("drain_empty", evt_valid, 0);
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [9:0] ev;
        if ((m_brk || m_ext) && (cyc - prefix_cyc) > 2 * TIMEOUT) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        if (b == 8'hE0) begin
            m_ext = 1'b1;
            prefix_cyc = cyc;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
            prefix_cyc = cyc;
        end else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            ev = {m_brk, m_ext, b};
            if (b == JUMP && !m_ext) m_jump = !m_brk;
            if (mq.size() < DEPTH) mq.push_back(ev);
            else m_ovf = 1'b1;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic cmp_state(input string tag);
        logic [9:0] head;
        head = (mq.size() != 0) ? mq[0] : 10'h000;
        check({tag, "_valid"}, evt_valid, (mq.size() != 0) ? 1 : 0);
        check({tag, "_data"}, evt_data, head);
        check({tag, "_overflow"}, overflow, m_ovf);
        check({tag, "_jump"}, jump_down, m_jump);
    endtask

    initial begin
        logic [7:0] b;
        logic [9:0] expd;
        int gap;
        int r;

        // ---------------- reset state ----------------
        rst = 1'b0;
        tick(); tick(); tick();
        check("rst_read_ack", read_ack, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_data", evt_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_jump", jump_down, 0);
        rst = 1'b1;
        tick();

        // ---------------- first byte, received held 3 clk ----------------
        send_byte(8'h1C, 3, 0, 0);
        check("first_valid", evt_valid, 1);
        check("first_data", evt_data, 10'h01C);

        // ---------------- table-driven sequences ----------------
        vt[0] = '{24'h000029, 1, 1'b1, 10'h029, 1'b1};
        vt[1] = '{24'h0029F0, 2, 1'b1, 10'h229, 1'b0};
        vt[2] = '{24'h75F0E0, 3, 1'b1, 10'h375, 1'b0};
        vt[3] = '{24'h0000AA, 1, 1'b0, 10'h000, 1'b0};
        vt[4] = '{24'h0029E0, 2, 1'b1, 10'h129, 1'b0};
        vt[5] = '{24'h1CAAF0, 3, 1'b1, 10'h21C, 1'b0};
        vt[6] = '{24'h000029, 1, 1'b1, 10'h029, 1'b1};
        vt[7] = '{24'h29F0E0, 3, 1'b1, 10'h329, 1'b1};
        vt[8] = '{24'h0000FA, 1, 1'b0, 10'h000, 1'b1};
        vt[9] = '{24'h0029F0, 2, 1'b1, 10'h229, 1'b0};
        for (int k = 0; k < 10; k++) begin
            drain();
            for (int j = 0; j < vt[k].n; j++) begin
                send_byte(vt[k].bytes[8*j +: 8], 1 + (j % 2), 0, 0);
            end
            check($sformatf("vec%0d_valid", k), evt_valid, vt[k].ev);
            check($sformatf("vec%0d_data", k), evt_data, vt[k].data);
            check($sformatf("vec%0d_jump", k), jump_down, vt[k].jmp);
        end

        // ---------------- prefix timeout ----------------
        drain();
        send_byte(8'hE0, 1, 0, 0);
        for (int i = 0; i < TIMEOUT + 5; i++) tick();
        send_byte(8'h6B, 1, 0, 0);
        check("timeout_data", evt_data, 10'h06B);

        // ---------------- overflow, push+pop while full, ovf_clr ----------------
        drain();
        for (int i = 0; i <= DEPTH; i++) begin
            b = 8'(8'h10 + i);
            send_byte(b, 1, 0, 0);
        end
        check("ovf_set", overflow, 1);
        check("ovf_head", evt_data, 10'h010);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clear1", overflow, 0);
        send_byte(8'h19, 1, 0, 1);
        check("ovf_set_wins", overflow, 1);
        send_byte(8'h20, 1, 1, 0);
        check("full_pushpop_head", evt_data, 10'h011);
        for (int i = 0; i < DEPTH; i++) begin
            expd = (i == DEPTH - 1) ? 10'h020 : 10'(10'h011 + i);
            check($sformatf("full_order%0d_valid", i), evt_valid, 1);
            check($sformatf("full_order%0d_data", i), evt_data, expd);
            evt_pop = 1'b1;
            tick();
            evt_pop = 1'b0;
        end
        check("full_after_drain", evt_valid, 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clear2", overflow, 0);

        // ---------------- push+pop while empty ----------------
        send_byte(8'h33, 1, 1, 0);
        check("empty_pushpop_valid", evt_valid, 1);
        check("empty_pushpop_data", evt_data, 10'h033);
        drain();

        // ---------------- reset mid-ACK ----------------
        send_byte(8'h29, 1, 0, 0);
        send_byte(8'hE0, 1, 0, 0);
        received      = 1'b1;
        received_data = 8'h1C;
        tick();
        tick();
        check("midack_read_ack", read_ack, 1);
        rst = 1'b0;
        #1;
        check("midack_rst_read_ack", read_ack, 0);
        check("midack_rst_valid", evt_valid, 0);
        check("midack_rst_data", evt_data, 0);
        check("midack_rst_jump", jump_down, 0);
        received = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        send_byte(8'h5A, 2, 0, 0);
        check("post_rst_valid", evt_valid, 1);
        check("post_rst_data", evt_data, 10'h05A);
        drain();

        // ---------------- randomized traffic against the model ----------------
        mq.delete();
        m_ovf = 1'b0; m_jump = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
        prefix_cyc = cyc;
        for (int it = 0; it < 400; it++) begin
            gap = $urandom_range(0, 5);
            if ($urandom_range(0, 15) == 0) gap = 3 * TIMEOUT;
            // Keep every pending prefix either well inside or well past its
            // timeout so the expected outcome is unambiguous.
            if ((m_brk || m_ext) && (int'(cyc - prefix_cyc) + gap + 6) > TIMEOUT / 2)
                gap = 3 * TIMEOUT;
            for (int g = 0; g < gap; g++) begin
                if (g < 6) cmp_state("rnd_idle");
                evt_pop = ($urandom_range(0, 2) == 0);
                ovf_clr = ($urandom_range(0, 11) == 0);
                tick();
                if (evt_pop && mq.size() != 0) void'(mq.pop_front());
                if (ovf_clr) m_ovf = 1'b0;
                evt_pop = 1'b0;
                ovf_clr = 1'b0;
            end
            r = $urandom_range(0, 9);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = JUMP;
                3: b = 8'hAA;
                4: begin
                    case ($urandom_range(0, 4))
                        0: b = 8'hFA;
                        1: b = 8'hEE;
                        2: b = 8'hFE;
                        3: b = 8'h00;
                        default: b = 8'hFF;
                    endcase
                end
                default: b = 8'($urandom_range(1, 8'h7F));
            endcase
            send_byte(b, $urandom_range(1, 3), 0, 0);
            model_byte(b);
            cmp_state("rnd_byte");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
